cpu_dbg_cmd_ctrl: RTL and testbench
===================================

# cpu_dbg_cmd_ctrl

Parametrised host-command controller between the UART word receiver/transmitter pair and the CPU core. It decodes command words from the host, drives CPU reset, single-step, bounded-run and free-run control, and returns status and data words: PC, register file and the step count. It replaces per-command pulse detection with valid/ready handshakes and adds argument-carrying commands.

## Interface
- DATA_W, 32: width of command, response, PC and register data words (≥16).
- REG_AW, 5: register-file address width.
- CNT_W, 16: run-cycle counter width.
- RESET_CYC, 4: cycles cpu_reset is held asserted (≥1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  command word available from the UART receiver.
- rx_ready  out  1  controller accepts rx_data this cycle.
- rx_data  in  DATA_W  command: [7:0] opcode, [DATA_W-1:8] argument.
- tx_valid  out  1  response word valid to the UART transmitter.
- tx_ready  in  1  transmitter accepts tx_data.
- tx_data  out  DATA_W  response word.
- pc  in  DATA_W  current CPU program counter.
- dbg_raddr  out  REG_AW  register-file debug read address.
- dbg_rdata  in  DATA_W  register-file data, valid 1 cycle after dbg_raddr.
- cpu_reset  out  1  CPU reset.
- cpu_run  out  1  CPU clock enable; CPU advances one instruction per high cycle.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, DECODE, RST, RUN_N, FREE, RD_WAIT, TX_STAT, TX_DATA.
- IDLE: rx_ready=1. A handshake (rx_valid&rx_ready) latches opcode and argument, then the FSM enters DECODE.
- Opcodes:
  - 0x01 RESET → RST.
  - 0x02 READ_PC → latch pc into data register → TX_STAT, then TX_DATA.
  - 0x03 STEP: arg[CNT_W-1:0]=N. N=0 → NACK. Otherwise load counter=N → RUN_N.
  - 0x04 READ_REG: dbg_raddr=arg[REG_AW-1:0] → RD_WAIT (1 cycle), latch dbg_rdata → TX_STAT, then TX_DATA.
  - 0x05 RUN → FREE.
  - 0x06 HALT: when the CPU is not running → ACK with no other effect.
  - Any other opcode → NACK.
- Status word: ACK = {zeros, 1'b1, opcode[6:0]} (opcode|0x80); NACK = {zeros, 8'hFF}.
- RST: cpu_reset=1 for RESET_CYC cycles, cpu_run=0, step counter cleared → TX_STAT (ACK 0x81).
- RUN_N: cpu_run=1 each cycle and the counter decrements. The FSM leaves after exactly N run cycles → TX_STAT (ACK 0x83), then TX_DATA = the pc sampled the cycle after the last run cycle.
- FREE: cpu_run=1 continuously and rx_ready=1.
  - HALT accepted → cpu_run=0 from the next cycle → TX_STAT (ACK 0x86), then TX_DATA = pc.
  - Any other accepted word in FREE → NACK; cpu_run stays 1 while the NACK is sent, then the FSM returns to FREE.
- TX_STAT/TX_DATA: tx_valid=1, and tx_data is held stable until tx_ready. A handshake advances to TX_DATA (if the command has data) or to IDLE (or FREE for the NACK-in-FREE case).
- rx_ready=0 in every state except IDLE and FREE. Commands arriving while busy wait in the receiver.

## Timing
- Reset values: state=IDLE, rx_ready=1 (the first cycle after reset is released), tx_valid=0, tx_data=0, dbg_raddr=0, cpu_reset=0, cpu_run=0, busy=0. The counter and data register are cleared.
- All outputs are registered, except rx_ready and busy, which are decoded from state.
- Command accept (cycle T) → DECODE at T+1 → action state at T+2.
- READ_PC: tx_valid is high from T+2. READ_REG: tx_valid is high from T+3.
- STEP N: cpu_run is high on cycles T+2 … T+N+1; the status word is valid at T+N+2.
- RESET: cpu_reset is high on cycles T+2 … T+RESET_CYC+1.
- tx_valid, once raised, is held until the handshake; tx_data does not change while tx_valid=1 and tx_ready=0.
- reset mid-operation: the FSM returns to IDLE next cycle, cpu_run and cpu_reset drop, and any pending response is discarded.
- rx_valid and tx_ready asserted in the same cycle: each handshake is evaluated independently. In FREE, HALT is still accepted while a NACK is pending only after that NACK completes (rx_ready=0 during TX_*).
- Counter is CNT_W bits; N=2^CNT_W-1 is the largest step and runs the full count with no wrap.

## Test plan
- After reset, send 0x00000001 → cpu_reset high for 4 cycles, then tx 0x00000081; busy falls after tx handshake.
- Send 0x00000002 with pc=0x00000040 → tx 0x00000082, then 0x00000040. Hold tx_ready low 10 cycles; tx_data must stay stable.
- Send 0x00000503 (N=5) → cpu_run high exactly 5 consecutive cycles → tx 0x83, then pc. Send 0x00000003 (N=0) → tx 0xFF, cpu_run never asserts.
- Send 0x00000A04 → dbg_raddr=10; dbg_rdata=0xDEADBEEF → tx 0x84, then 0xDEADBEEF.
- Send 0x05; while in FREE send 0x02 → tx 0xFF with cpu_run still 1; then send 0x06 → cpu_run drops next cycle → tx 0x86, then pc.
- Assert reset during STEP N=1000 at cycle 20 → cpu_run=0, tx_valid=0, busy=0 next cycle; opcode 0x7F afterwards → NACK 0xFF.

Source files
------------

// File: rtl/cpu_dbg_cmd_ctrl.sv
// cpu_dbg_cmd_ctrl
//   Host-command controller between the UART word receiver/transmitter and
//   the CPU core. Decodes command words (opcode in [7:0], argument above),
//   drives CPU reset / single-step / bounded-run / free-run, and returns a
//   status word optionally followed by a data word (PC or register value).
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   rx_valid/ready    : command word handshake, rx_data = {arg, opcode}
//   tx_valid/ready    : response word handshake, tx_data = response
//   pc                : current CPU program counter
//   dbg_raddr/rdata   : register-file debug read port (1-cycle latency)
//   cpu_reset         : CPU reset
//   cpu_run           : CPU clock enable (one instruction per high cycle)
//   busy              : controller is not idle
module cpu_dbg_cmd_ctrl #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int RESET_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic [DATA_W-1:0] pc,
  output logic [REG_AW-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              busy
);

  localparam logic [7:0] OP_RESET    = 8'h01;
  localparam logic [7:0] OP_READ_PC  = 8'h02;
  localparam logic [7:0] OP_STEP     = 8'h03;
  localparam logic [7:0] OP_READ_REG = 8'h04;
  localparam logic [7:0] OP_RUN      = 8'h05;
  localparam logic [7:0] OP_HALT     = 8'h06;

  localparam logic [DATA_W-1:0] NACK = {{(DATA_W-8){1'b0}}, 8'hFF};

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RST, S_RUN_N, S_FREE, S_RD_WAIT, S_TX_STAT, S_TX_DATA
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        op_reg, op_next;
  logic [CNT_W-1:0]  arg_reg, arg_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic [REG_AW-1:0] dbg_raddr_reg, dbg_raddr_next;
  logic              cpu_reset_reg, cpu_reset_next;
  logic              cpu_run_reg, cpu_run_next;
  logic              has_data_reg, has_data_next;   // status is followed by a data word
  logic              to_free_reg, to_free_next;     // NACK sent from FREE: return there
  logic              grab_pc_reg, grab_pc_next;     // sample pc on the first TX_STAT cycle

  logic rx_fire, tx_fire;

  // Only the step count is kept from the argument; higher argument bits are don't-care.
  generate
    if (DATA_W > CNT_W + 8) begin : g_unused_arg
      logic unused_arg;
      assign unused_arg = &{1'b0, rx_data[DATA_W-1:CNT_W+8]};
    end
  endgenerate

  function automatic logic [DATA_W-1:0] ack(input logic [7:0] op);
    return {{(DATA_W-8){1'b0}}, 1'b1, op[6:0]};
  endfunction

  assign rx_ready  = (state_reg == S_IDLE) || (state_reg == S_FREE);
  assign busy      = (state_reg != S_IDLE);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid_reg && tx_ready;

  assign tx_valid  = tx_valid_reg;
  assign tx_data   = tx_data_reg;
  assign dbg_raddr = dbg_raddr_reg;
  assign cpu_reset = cpu_reset_reg;
  assign cpu_run   = cpu_run_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      arg_reg       <= '0;
      cnt_reg       <= '0;
      data_reg      <= '0;
      tx_valid_reg  <= 1'b0;
      tx_data_reg   <= '0;
      dbg_raddr_reg <= '0;
      cpu_reset_reg <= 1'b0;
      cpu_run_reg   <= 1'b0;
      has_data_reg  <= 1'b0;
      to_free_reg   <= 1'b0;
      grab_pc_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      arg_reg       <= arg_next;
      cnt_reg       <= cnt_next;
      data_reg      <= data_next;
      tx_valid_reg  <= tx_valid_next;
      tx_data_reg   <= tx_data_next;
      dbg_raddr_reg <= dbg_raddr_next;
      cpu_reset_reg <= cpu_reset_next;
      cpu_run_reg   <= cpu_run_next;
      has_data_reg  <= has_data_next;
      to_free_reg   <= to_free_next;
      grab_pc_reg   <= grab_pc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    arg_next       = arg_reg;
    cnt_next       = cnt_reg;
    data_next      = grab_pc_reg ? pc : data_reg;
    tx_valid_next  = tx_valid_reg;
    tx_data_next   = tx_data_reg;
    dbg_raddr_next = dbg_raddr_reg;
    cpu_reset_next = cpu_reset_reg;
    cpu_run_next   = cpu_run_reg;
    has_data_next  = has_data_reg;
    to_free_next   = to_free_reg;
    grab_pc_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rx_fire) begin
          op_next      = rx_data[7:0];
          arg_next     = rx_data[CNT_W+7:8];
          to_free_next = 1'b0;
          // Address goes out during DECODE so rdata is ready in RD_WAIT.
          if (rx_data[7:0] == OP_READ_REG)
            dbg_raddr_next = rx_data[REG_AW+7:8];
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Default outcome is a status-only response; cases below override.
        tx_valid_next = 1'b1;
        tx_data_next  = NACK;
        has_data_next = 1'b0;
        state_next    = S_TX_STAT;
        case (op_reg)
          OP_RESET: begin
            tx_valid_next  = 1'b0;
            cnt_next       = CNT_W'(RESET_CYC);
            cpu_reset_next = 1'b1;
            cpu_run_next   = 1'b0;
            state_next     = S_RST;
          end
          OP_READ_PC: begin
            data_next     = pc;
            tx_data_next  = ack(op_reg);
            has_data_next = 1'b1;
          end
          OP_STEP: begin
            if (arg_reg != '0) begin
              tx_valid_next = 1'b0;
              cnt_next      = arg_reg;
              cpu_run_next  = 1'b1;
              state_next    = S_RUN_N;
            end
          end
          OP_READ_REG: begin
            tx_valid_next = 1'b0;
            state_next    = S_RD_WAIT;
          end
          OP_RUN: begin
            tx_valid_next = 1'b0;
            cpu_run_next  = 1'b1;
            state_next    = S_FREE;
          end
          OP_HALT: tx_data_next = ack(op_reg);
          default: ;
        endcase
      end

      S_RST: begin
        // Counter runs down to zero, which also leaves the step count cleared.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          cpu_reset_next = 1'b0;
          tx_valid_next  = 1'b1;
          tx_data_next   = ack(op_reg);
          has_data_next  = 1'b0;
          state_next     = S_TX_STAT;
        end
      end

      S_RUN_N: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          cpu_run_next  = 1'b0;
          tx_valid_next = 1'b1;
          tx_data_next  = ack(op_reg);
          has_data_next = 1'b1;
          grab_pc_next  = 1'b1;
          state_next    = S_TX_STAT;
        end
      end

      S_FREE: begin
        if (rx_fire) begin
          tx_valid_next = 1'b1;
          state_next    = S_TX_STAT;
          if (rx_data[7:0] == OP_HALT) begin
            cpu_run_next  = 1'b0;
            tx_data_next  = ack(OP_HALT);
            has_data_next = 1'b1;
            grab_pc_next  = 1'b1;
            to_free_next  = 1'b0;
          end else begin
            tx_data_next  = NACK;
            has_data_next = 1'b0;
            to_free_next  = 1'b1;
          end
        end
      end

      S_RD_WAIT: begin
        data_next     = dbg_rdata;
        tx_valid_next = 1'b1;
        tx_data_next  = ack(op_reg);
        has_data_next = 1'b1;
        state_next    = S_TX_STAT;
      end

      S_TX_STAT: begin
        if (tx_fire) begin
          if (has_data_reg) begin
            // If the handshake lands on the pc-sampling cycle, take pc directly.
            tx_data_next = grab_pc_reg ? pc : data_reg;
            state_next   = S_TX_DATA;
          end else begin
            tx_valid_next = 1'b0;
            state_next    = to_free_reg ? S_FREE : S_IDLE;
          end
        end
      end

      S_TX_DATA: begin
        if (tx_fire) begin
          tx_valid_next = 1'b0;
          state_next    = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_dbg_cmd_ctrl.sv
// Directed testbench for cpu_dbg_cmd_ctrl. Outputs are sampled on the
// falling edge; inputs change on the falling edge. A tiny CPU model counts
// run cycles (pc = pc_base + 4*run_cnt) and a register file answers reads
// with one cycle of latency.
module tb_cpu_dbg_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] rx_data = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic [31:0] pc;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        cpu_reset;
  logic        cpu_run;
  logic        busy;

  logic [31:0] pc_base = '0;
  int          run_cnt;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cpu_dbg_cmd_ctrl #(.DATA_W(32), .REG_AW(5), .CNT_W(16), .RESET_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .pc(pc), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .cpu_reset(cpu_reset), .cpu_run(cpu_run), .busy(busy)
  );

  always_ff @(posedge clk) begin
    if (reset) run_cnt <= 0;
    else if (cpu_run) run_cnt <= run_cnt + 1;
  end
  assign pc = pc_base + 32'(run_cnt) * 32'd4;

  always_ff @(posedge clk)
    dbg_rdata <= (dbg_raddr == 5'd10) ? 32'hDEADBEEF : {27'd0, dbg_raddr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one command word; returns at the falling edge of the cycle after accept.
  task automatic send(input logic [31:0] word);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = word;
    chk("rx_ready_at_send", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  // Wait (bounded) for a response, optionally hold tx_ready low, then take it.
  task automatic recv(input string tag, input logic [31:0] exp, input int hold, input int bound);
    int w = 0;
    while (!tx_valid && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, tx_data, exp);
    end
    chk(tag, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    int          r0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_dbg_raddr", 32'(dbg_raddr), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // RESET: cpu_reset on T+2..T+5, ACK 0x81 at T+6
    send(32'h0000_0001);
    chk("reset_decode_busy", 32'(busy), 32'd1);
    chk("reset_T1_cpu_reset", 32'(cpu_reset), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_cpu_reset_high", 32'(cpu_reset), 32'd1);
      chk("reset_no_tx", 32'(tx_valid), 32'd0);
    end
    @(negedge clk);
    chk("reset_cpu_reset_low", 32'(cpu_reset), 32'd0);
    chk("reset_ack_timing", 32'(tx_valid), 32'd1);
    recv("reset_ack", 32'h81, 0, 4);
    chk("reset_busy_after", 32'(busy), 32'd0);
    chk("reset_tx_valid_after", 32'(tx_valid), 32'd0);

    // READ_PC with tx_ready held low 10 cycles
    pc_base = 32'h40;
    send(32'h0000_0002);
    chk("rdpc_T1_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("rdpc_T2_tx_valid", 32'(tx_valid), 32'd1);
    recv("rdpc_ack", 32'h82, 10, 4);
    recv("rdpc_data", 32'h40, 3, 4);
    chk("rdpc_busy_after", 32'(busy), 32'd0);

    // STEP N=5: cpu_run on T+2..T+6, status at T+7, pc = 0x40 + 5*4
    send(32'h0000_0503);
    chk("step5_T1_run", 32'(cpu_run), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("step5_run_high", 32'(cpu_run), 32'd1);
    end
    @(negedge clk);
    chk("step5_run_low", 32'(cpu_run), 32'd0);
    chk("step5_ack_timing", 32'(tx_valid), 32'd1);
    recv("step5_ack", 32'h83, 0, 4);
    recv("step5_pc", 32'h54, 0, 4);

    // STEP N=0 -> NACK, no run
    send(32'h0000_0003);
    @(negedge clk);
    chk("step0_run", 32'(cpu_run), 32'd0);
    recv("step0_nack", 32'hFF, 0, 4);
    chk("step0_run_count", 32'(run_cnt), 32'd5);

    // READ_REG 10
    send(32'h0000_0A04);
    chk("rdreg_raddr", 32'(dbg_raddr), 32'd10);
    @(negedge clk);
    chk("rdreg_T2_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("rdreg_T3_tx_valid", 32'(tx_valid), 32'd1);
    recv("rdreg_ack", 32'h84, 0, 4);
    recv("rdreg_data", 32'hDEADBEEF, 0, 4);

    // HALT while idle: ACK only
    send(32'h0000_0006);
    recv("halt_idle_ack", 32'h86, 0, 4);
    chk("halt_idle_no_data", 32'(tx_valid), 32'd0);
    chk("halt_idle_busy", 32'(busy), 32'd0);

    // RUN, foreign command in FREE -> NACK while running, then HALT
    send(32'h0000_0005);
    @(negedge clk);
    chk("free_run", 32'(cpu_run), 32'd1);
    chk("free_rx_ready", 32'(rx_ready), 32'd1);
    repeat (3) @(negedge clk);
    send(32'h0000_0002);
    chk("free_nack_run", 32'(cpu_run), 32'd1);
    chk("free_nack_rx_ready", 32'(rx_ready), 32'd0);
    recv("free_nack", 32'hFF, 2, 4);
    chk("free_back_run", 32'(cpu_run), 32'd1);
    chk("free_back_rx_ready", 32'(rx_ready), 32'd1);
    send(32'h0000_0006);
    chk("halt_run_low", 32'(cpu_run), 32'd0);
    exp_pc = pc;
    recv("halt_ack", 32'h86, 1, 4);
    recv("halt_pc", exp_pc, 0, 4);
    chk("halt_busy_after", 32'(busy), 32'd0);

    // Largest step count: full 2^16-1 run cycles, no wrap
    r0 = run_cnt;
    send(32'h00FF_FF03);
    recv("stepmax_ack", 32'h83, 0, 70000);
    chk("stepmax_cycles", 32'(run_cnt - r0), 32'd65535);
    exp_pc = pc;
    recv("stepmax_pc", exp_pc, 0, 4);

    // Reset in the middle of STEP N=1000
    send(32'h0003_E803);
    repeat (18) @(negedge clk);
    chk("midrst_running", 32'(cpu_run), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_run", 32'(cpu_run), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd0);

    // Unknown opcode afterwards -> NACK
    send(32'h0000_007F);
    recv("unknown_nack", 32'hFF, 0, 4);
    chk("unknown_done", 32'(tx_valid), 32'd0);
    chk("unknown_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
